alu_cmd_ctrl: RTL and testbench

Command-side controller for the registered ALU (`alu_pkg` operations, 1-cycle result latency). It accepts tagged operation requests over a valid/ready handshake and registers them onto the ALU operand/opcode inputs. It tracks in-flight operations, captures each ALU result at the correct cycle into a result FIFO, and returns results in order with their tags over a second valid/ready handshake. A credit count prevents issuing more operations than the FIFO can absorb.

---
 rtl/alu_cmd_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// alu_pkg: opcode set of the registered ALU driven by this controller.
// alu_cmd_ctrl: issues tagged ALU requests and returns results in order through a credit-guarded FIFO.
package alu_pkg;
    typedef enum logic [2:0] {
        ADD     = 3'd0,
        SUB     = 3'd1,
        MULT    = 3'd2,
        FUNCRL  = 3'd3,
        FUNCRR  = 3'd4,
        OP_RSV5 = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } alu_op_t;
endpackage

module alu_cmd_ctrl
    import alu_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          flush_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  alu_op_t                       cmd_op_i,
    input  logic [DWIDTH-1:0]             cmd_a_i,
    input  logic [DWIDTH-1:0]             cmd_b_i,
    input  logic [TAG_W-1:0]              cmd_tag_i,
    output alu_op_t                       alu_op_o,
    output logic [DWIDTH-1:0]             alu_a_o,
    output logic [DWIDTH-1:0]             alu_b_o,
    input  logic [DWIDTH-1:0]             alu_res_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [DWIDTH-1:0]             res_data_o,
    output logic [TAG_W-1:0]              res_tag_o,
    output logic [$clog2(FIFO_DEPTH):0]   res_count_o,
    output logic                          busy_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic                 vld_p1, vld_p2;
    logic [TAG_W-1:0]     tag_p1, tag_p2;
    logic [DWIDTH-1:0]    fifo_data [FIFO_DEPTH];
    logic [TAG_W-1:0]     fifo_tag  [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic [CW:0]          committed;
    logic                 accept, push, pop, nonempty;

    // Credits cover every result already owed: FIFO entries plus both pipeline slots.
    // A pop this cycle is deliberately not counted so ready never depends on res_ready_i.
    assign committed   = {1'b0, count} + {{CW{1'b0}}, vld_p1} + {{CW{1'b0}}, vld_p2};
    assign cmd_ready_o = (committed < DEPTH_C) && !flush_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign nonempty    = (count != '0);
    assign push        = vld_p2 && !flush_i;
    assign pop         = res_ready_i && nonempty && !flush_i;

    // ---- S1: issue onto the ALU operand/opcode inputs ----
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            alu_op_o <= ADD;
            alu_a_o  <= '0;
            alu_b_o  <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1 && !flush_i;
            if (accept) begin
                alu_op_o <= cmd_op_i;
                alu_a_o  <= cmd_a_i;
                alu_b_o  <= cmd_b_i;
            end
        end
    end

    // ---- S2: tag follows the ALU's own result register ----
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_p1 <= cmd_tag_i;
        end
        tag_p2 <= tag_p1;
    end

    // ---- capture: result FIFO storage ----
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= alu_res_i;
            fifo_tag[wr_ptr]  <= tag_p2;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // ---- return: head of FIFO, forced to zero while empty ----
    assign res_valid_o = nonempty;
    assign res_data_o  = nonempty ? fifo_data[rd_ptr] : '0;
    assign res_tag_o   = nonempty ? fifo_tag[rd_ptr]  : '0;
    assign res_count_o = count;
    assign busy_o      = vld_p1 || vld_p2 || nonempty;

    // Credits must make a push into a full FIFO impossible unless the head leaves the same cycle.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (push && (count == CW'(FIFO_DEPTH))) |-> pop);
    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        count <= CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Scoreboard bench for alu_cmd_ctrl with a behavioural registered ALU attached.
module tb_alu_cmd_ctrl;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    alu_op_t       cmd_op_i = ADD;
    logic [DW-1:0] cmd_a_i = '0;
    logic [DW-1:0] cmd_b_i = '0;
    logic [TW-1:0] cmd_tag_i = '0;
    alu_op_t       alu_op_o;
    logic [DW-1:0] alu_a_o, alu_b_o;
    logic [DW-1:0] alu_res_i = '0;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [DW-1:0] res_data_o;
    logic [TW-1:0] res_tag_o;
    logic [2:0]    res_count_o;
    logic          busy_o;

    alu_cmd_ctrl #(.DWIDTH(DW), .TAG_W(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_tag_i(cmd_tag_i),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_res_i(alu_res_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
        .res_tag_o(res_tag_o), .res_count_o(res_count_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        int            vis;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            last_wait = 0;
    bit            rr_rand = 1'b0;
    logic [DW-1:0] cmd_exp = '0;

    function automatic logic [DW-1:0] alu_fn(alu_op_t op, logic [DW-1:0] a, logic [DW-1:0] b);
        logic [2*DW-1:0] t;
        case (op)
            ADD:    return a + b;
            SUB:    return a - b;
            MULT:   return DW'(a[15:0] * b[15:0]);
            FUNCRL: begin t = {a, a} << b[4:0]; return t[2*DW-1:DW]; end
            FUNCRR: begin t = {a, a} >> b[4:0]; return t[DW-1:0]; end
            default: return '0;
        endcase
    endfunction

    // Registered ALU: one-cycle latency from operands to result.
    always @(posedge clk_i) alu_res_i <= alu_fn(alu_op_o, alu_a_o, alu_b_o);

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every cycle compare handshakes and head against the outstanding-result model.
    always @(negedge clk_i) begin
        int vis_cnt;
        if (rst_n_i) begin
            vis_cnt = 0;
            foreach (q[i]) if (q[i].vis <= cyc) vis_cnt++;
            chk("cmd_ready", 64'(cmd_ready_o), 64'((q.size() < DEPTH) && !flush_i));
            chk("res_count", 64'(res_count_o), 64'(vis_cnt));
            chk("res_valid", 64'(res_valid_o), 64'(vis_cnt != 0));
            chk("busy", 64'(busy_o), 64'(q.size() != 0));
            if (res_valid_o && vis_cnt != 0) begin
                chk("head_data", 64'(res_data_o), 64'(q[0].data));
                chk("head_tag", 64'(res_tag_o), 64'(q[0].tag));
            end
            if (res_valid_o && res_ready_i && !flush_i && q.size() != 0) void'(q.pop_front());
            if (cmd_valid_i && cmd_ready_o) q.push_back('{data: cmd_exp, tag: cmd_tag_i, vis: cyc + 3});
            if (flush_i) q.delete();
        end
    end

    task automatic send(alu_op_t op, logic [DW-1:0] a, logic [DW-1:0] b,
                        logic [TW-1:0] tag, logic [DW-1:0] exp);
        int waited = 0;
        cmd_valid_i = 1'b1;
        cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; cmd_tag_i = tag; cmd_exp = exp;
        forever begin
            if (rr_rand) res_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            if (cmd_ready_o) begin
                @(posedge clk_i); #1;
                break;
            end
            waited++;
            if (waited > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout actual=stalled required=accepted tag=%0h", tag);
                @(posedge clk_i); #1;
                break;
            end
            @(posedge clk_i); #1;
        end
        last_wait = waited;
    endtask

    task automatic idle(int n);
        cmd_valid_i = 1'b0;
        repeat (n) begin
            if (rr_rand) res_ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk_i); #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid_i = 1'b0;
        rr_rand = 1'b0;
        res_ready_i = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("drain_done", 64'(q.size()), 64'd0);
        @(posedge clk_i); #1;
    endtask

    task automatic chk_reset_vals(string pfx);
        chk({pfx, "_alu_op"}, 64'(alu_op_o), 64'(ADD));
        chk({pfx, "_alu_a"}, 64'(alu_a_o), 64'd0);
        chk({pfx, "_alu_b"}, 64'(alu_b_o), 64'd0);
        chk({pfx, "_res_valid"}, 64'(res_valid_o), 64'd0);
        chk({pfx, "_res_data"}, 64'(res_data_o), 64'd0);
        chk({pfx, "_res_tag"}, 64'(res_tag_o), 64'd0);
        chk({pfx, "_res_count"}, 64'(res_count_o), 64'd0);
        chk({pfx, "_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] head_d;
        logic [TW-1:0] head_t;
        alu_op_t       op;
        logic [DW-1:0] a, b;

        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_vals("rst");
        rst_n_i = 1'b1;
        #1;
        chk("rst_ready", 64'(cmd_ready_o), 64'd1);
        @(posedge clk_i); #1;

        // Single ADD
        res_ready_i = 1'b1;
        send(ADD, 32'd5, 32'd7, 4'd3, 32'd12);
        chk("add_nowait", 64'(last_wait), 64'd0);
        drain();
        chk("add_idle_busy", 64'(busy_o), 64'd0);

        // Mixed stream, back to back
        send(MULT, 32'h0001_0003, 32'h0002_0004, 4'd0, 32'h0000_000C);
        chk("mix0_stall", 64'(last_wait), 64'd0);
        send(FUNCRL, 32'h8000_0001, 32'd1, 4'd1, 32'h0000_0003);
        chk("mix1_stall", 64'(last_wait), 64'd0);
        send(FUNCRR, 32'h0000_0001, 32'd4, 4'd2, 32'h1000_0000);
        chk("mix2_stall", 64'(last_wait), 64'd0);
        send(SUB, 32'd3, 32'd5, 4'd3, 32'hFFFF_FFFE);
        chk("mix3_stall", 64'(last_wait), 64'd0);
        drain();

        // Backpressure: four accepted, fifth held off
        res_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(ADD, 32'(i * 10), 32'd1, 4'(8 + i), 32'(i * 10 + 1));
            chk("bp_accept_stall", 64'(last_wait), 64'd0);
        end
        cmd_valid_i = 1'b1;
        cmd_op_i = SUB; cmd_a_i = 32'd100; cmd_b_i = 32'd1; cmd_tag_i = 4'd12; cmd_exp = 32'd99;
        repeat (4) begin
            @(negedge clk_i);
            chk("bp_ready_low", 64'(cmd_ready_o), 64'd0);
            @(posedge clk_i); #1;
        end
        chk("bp_count", 64'(res_count_o), 64'd4);
        head_d = res_data_o;
        head_t = res_tag_o;
        repeat (2) @(posedge clk_i);
        #1;
        chk("bp_head_data_stable", 64'(res_data_o), 64'(head_d));
        chk("bp_head_tag_stable", 64'(res_tag_o), 64'(head_t));
        chk("bp_head_tag", 64'(res_tag_o), 64'd8);
        res_ready_i = 1'b1;
        send(SUB, 32'd100, 32'd1, 4'd12, 32'd99);
        chk("bp_resume_wait", 64'(last_wait), 64'd1);
        drain();

        // Randomized traffic with random backpressure and gaps; wraps pointers many times
        rr_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            op = alu_op_t'(3'($urandom_range(0, 7)));
            a = $urandom;
            b = $urandom;
            send(op, a, b, 4'(i), alu_fn(op, a, b));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        drain();

        // Flush with two in flight and two in the FIFO; accept held during flush
        res_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(ADD, 32'(i), 32'd2, 4'(4 + i), 32'(i + 2));
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        cmd_valid_i = 1'b0;
        chk("flush_valid", 64'(res_valid_o), 64'd0);
        chk("flush_count", 64'(res_count_o), 64'd0);
        chk("flush_busy", 64'(busy_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #1;
        chk("flush_no_stale", 64'(res_valid_o), 64'd0);
        res_ready_i = 1'b1;
        send(ADD, 32'd1, 32'd1, 4'd9, 32'd2);
        drain();

        // Asynchronous reset between accept and push
        send(ADD, 32'd2, 32'd3, 4'd5, 32'd5);
        cmd_valid_i = 1'b0;
        @(posedge clk_i); #2;
        rst_n_i = 1'b0;
        q.delete();
        #1;
        chk_reset_vals("arst");
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        chk("arst_no_stale", 64'(res_valid_o), 64'd0);
        chk("arst_ready", 64'(cmd_ready_o), 64'd1);
        send(MULT, 32'd6, 32'd7, 4'd14, 32'd42);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
